// File: rtl/multi_port_circular_buffer_if.sv
// Bus bundle for the parallel-access circular buffer: the write-side and read-side
// handshakes plus the pointer/occupancy status consumed by downstream space checking.
interface multi_port_circular_buffer_if #(
  parameter int PAR_WRITE    = 2,
  parameter int PAR_READ     = 4,
  parameter int POINTER_SIZE = 3,
  parameter int DATA_WIDTH   = 8
);
  logic                             wen;
  logic [PAR_WRITE*DATA_WIDTH-1:0]  din;
  logic                             ready;
  logic                             ren;
  logic [PAR_READ*DATA_WIDTH-1:0]   dout;
  logic                             valid;
  logic [POINTER_SIZE-1:0]          write_pointer;
  logic [POINTER_SIZE-1:0]          read_pointer;
  logic [POINTER_SIZE-1:0]          count;
  logic                             full;
  logic                             empty;
  logic                             wr_err;
  logic                             rd_err;

  modport master (
    output wen, din, ren,
    input  ready, dout, valid, write_pointer, read_pointer, count, full, empty, wr_err, rd_err
  );

  modport slave (
    input  wen, din, ren,
    output ready, dout, valid, write_pointer, read_pointer, count, full, empty, wr_err, rd_err
  );
endinterface

// File: rtl/multi_port_circular_buffer.sv
// Circular buffer of 2^POINTER_SIZE words: PAR_WRITE words enter per write beat,
// PAR_READ words leave per read beat, dout falls through combinationally from rp.
module multi_port_circular_buffer #(
  parameter int PAR_WRITE    = 2,
  parameter int PAR_READ     = 4,
  parameter int POINTER_SIZE = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  multi_port_circular_buffer_if.slave   bus
);
  localparam int DEPTH = 1 << POINTER_SIZE;
  localparam logic [POINTER_SIZE-1:0] WRITE_STEP = POINTER_SIZE'(PAR_WRITE);
  localparam logic [POINTER_SIZE-1:0] READ_STEP  = POINTER_SIZE'(PAR_READ);

  logic [POINTER_SIZE-1:0] wp_reg, wp_next;
  logic [POINTER_SIZE-1:0] rp_reg, rp_next;
  logic                    wr_err_reg, wr_err_next;
  logic                    rd_err_reg, rd_err_next;
  logic [POINTER_SIZE-1:0] occupancy;
  logic [POINTER_SIZE-1:0] free_slots;
  logic                    can_write, can_read;
  logic                    write_accept, read_accept;
  logic [DATA_WIDTH-1:0]   din_lanes [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_view  [DEPTH];

  // Natural POINTER_SIZE-bit wrap gives the modulo arithmetic for free.
  assign occupancy  = wp_reg - rp_reg;
  assign free_slots = {POINTER_SIZE{1'b1}} - occupancy;
  assign can_write  = (free_slots >= WRITE_STEP);
  assign can_read   = (occupancy >= READ_STEP);

  assign write_accept = bus.wen && can_write;
  assign read_accept  = bus.ren && can_read;

  always_comb begin
    wp_next     = wp_reg;
    rp_next     = rp_reg;
    wr_err_next = bus.wen && !can_write;
    rd_err_next = bus.ren && !can_read;
    if (write_accept) begin
      wp_next = wp_reg + WRITE_STEP;
    end
    if (read_accept) begin
      rp_next = rp_reg + READ_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg     <= '0;
      rp_reg     <= '0;
      wr_err_reg <= 1'b0;
      rd_err_reg <= 1'b0;
    end else begin
      wp_reg     <= wp_next;
      rp_reg     <= rp_next;
      wr_err_reg <= wr_err_next;
      rd_err_reg <= rd_err_next;
    end
  end

  // Lanes beyond PAR_WRITE read as zero so any lane offset indexes in range.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_din_lane
      if (gi < PAR_WRITE) begin : g_used
        assign din_lanes[gi] = bus.din[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_unused
        assign din_lanes[gi] = '0;
      end
    end
  endgenerate

  // Each word decides for itself which write lane (if any) lands on it this beat.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [POINTER_SIZE-1:0] lane_offset;
      logic [DATA_WIDTH-1:0]   word_reg;

      assign lane_offset = POINTER_SIZE'(gi) - wp_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (write_accept && (lane_offset < WRITE_STEP)) begin
          word_reg <= din_lanes[lane_offset];
        end
      end

      assign mem_view[gi] = word_reg;
    end
  endgenerate

  generate
    for (gi = 0; gi < PAR_READ; gi++) begin : g_dout_lane
      assign bus.dout[gi*DATA_WIDTH +: DATA_WIDTH] = mem_view[rp_reg + POINTER_SIZE'(gi)];
    end
  endgenerate

  assign bus.ready         = can_write;
  assign bus.valid         = can_read;
  assign bus.write_pointer = wp_reg;
  assign bus.read_pointer  = rp_reg;
  assign bus.count         = occupancy;
  assign bus.full          = (occupancy == {POINTER_SIZE{1'b1}});
  assign bus.empty         = (occupancy == '0);
  assign bus.wr_err        = wr_err_reg;
  assign bus.rd_err        = rd_err_reg;
endmodule

// File: doc/multi_port_circular_buffer.md
# multi_port_circular_buffer

Storage and pointer stage of the parallel-access FIFO: holds 2^POINTER_SIZE words, accepts PAR_WRITE words per write beat and delivers PAR_READ words per read beat. It owns the write and read pointers and computes occupancy, so the downstream space checker consumes pointers that are correct by construction. It sits between the producer (wide write side) and the consumer (wide read side).

## Interface
- PAR_WRITE, 2, words written per accepted write beat; 1 ≤ PAR_WRITE ≤ 2^POINTER_SIZE−1.
- PAR_READ, 4, words read per accepted read beat; 1 ≤ PAR_READ ≤ 2^POINTER_SIZE−1.
- POINTER_SIZE, 3, pointer width; DEPTH = 2^POINTER_SIZE, usable capacity DEPTH−1.
- DATA_WIDTH, 8, bits per word.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wen  in  1  write request for this cycle.
- din  in  PAR_WRITE*DATA_WIDTH  write words; lane i = din[i*DATA_WIDTH +: DATA_WIDTH].
- ready  out  1  write beat can be accepted this cycle.
- ren  in  1  read request for this cycle.
- dout  out  PAR_READ*DATA_WIDTH  read words; lane i = mem[(rp+i) mod DEPTH].
- valid  out  1  PAR_READ words are available on dout.
- write_pointer  out  POINTER_SIZE  current write pointer wp.
- read_pointer  out  POINTER_SIZE  current read pointer rp.
- count  out  POINTER_SIZE  occupancy, (wp−rp) mod DEPTH.
- full  out  1  count == DEPTH−1.
- empty  out  1  count == 0.
- wr_err  out  1  registered one-cycle pulse: write rejected in the previous cycle.
- rd_err  out  1  registered one-cycle pulse: read rejected in the previous cycle.

## Operation
- State: mem[DEPTH] of DATA_WIDTH, wp, rp, wr_err, rd_err registers. There is no FSM beyond the pointers.
- count = (wp − rp) mod DEPTH, computed in POINTER_SIZE bits with natural wrap.
- free = DEPTH−1−count.
- ready = (free ≥ PAR_WRITE). valid = (count ≥ PAR_READ). Both are combinational from the registered pointers.
- Write accept: wen && ready.
  - On accept, mem[(wp+i) mod DEPTH] ← lane i for i = 0..PAR_WRITE−1.
  - wp ← (wp+PAR_WRITE) mod DEPTH.
- Read accept: ren && valid. On accept, rp ← (rp+PAR_READ) mod DEPTH.
- dout is first-word-fall-through: it is combinational from mem and rp. Its contents are don't-care while valid=0.
- Partial transfers are not allowed. A beat is all-or-nothing, and a rejected beat changes no state.
- Simultaneous write and read: both acceptances are evaluated against the pre-edge count, and both apply on the same edge. A read never returns words written on the same edge.
- Rejections:
  - wen && !ready: wr_err=1 for exactly the next cycle; mem and wp unchanged.
  - ren && !valid: rd_err=1 for exactly the next cycle; rp unchanged.
- Wrap-around: pointer and lane addresses wrap modulo DEPTH. A beat may straddle the DEPTH−1 → 0 boundary.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - wp=0, rp=0, all mem words=0, wr_err=0, rd_err=0.
  - Outputs follow: count=0, empty=1, full=0, ready=1 (given PAR_WRITE ≤ DEPTH−1), valid=0, dout=0.
- Reset mid-operation discards all contents. Any beat presented in the reset cycle is ignored.
- Write latency: data written at edge N is visible on dout after edge N. valid rises after edge N if count has reached PAR_READ.
- Read latency: 0 cycles. dout is valid in the same cycle valid=1. The pointer advances at the accepting edge.
- Throughput: one write beat and one read beat per cycle, back-to-back, with no bubbles.
- ready, valid, full, empty and count change only on clk edges or on rst.

## Test plan
- Reset then idle: assert rst mid-cycle → immediately count=0, empty=1, ready=1, valid=0, wr_err=rd_err=0, dout=0.
- Fill (defaults): write 0x11/0x22, 0x33/0x44, 0x55/0x66.
  - After the 3rd beat: count=6, wp=6, ready=0 (free=1<2), valid=1, dout lanes = 0x11,0x22,0x33,0x44.
  - A 4th wen → no state change and wr_err=1 the next cycle.
- Read and wrap: from count=6, ren → rp=4, count=2, valid=0, dout don't-care.
  - Write 0x77/0x88 → lands at mem[6], mem[7]; wp=0.
  - Write 0x99/0xAA → lands at mem[0], mem[1]; wp=2; count=6.
  - ren → dout = 0x55,0x66,0x77,0x88.
- Simultaneous: at count=4 (rp=0, wp=4), wen and ren in the same cycle.
  - After the edge: rp=4, wp=6, count=2.
  - Read data are the old 4 words; the new words are not included.
- Underflow: count=3, ren → rp unchanged, rd_err=1 for one cycle, then 0.
- Reset mid-stream: during back-to-back writes at count=4, pulse rst → all pointers 0. The next write beat is accepted at mem[0..1].
